boss_sequencer: RTL and testbench

BOSS_SEQUENCER -- requirements
Module: boss_sequencer

---
 rtl/boss_pkg.sv | 20 ++
 rtl/boss_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_boss_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/boss_pkg.sv
// Shared state encoding and default tuning constants for the boss encounter.
package boss_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTER  = 3'd1,
    ST_ATTACK = 3'd2,
    ST_DYING  = 3'd3,
    ST_DONE   = 3'd4
  } boss_state_e;

  localparam int unsigned BOSS_HEALTH_INIT  = 32'd8;
  localparam int unsigned BOSS_ENTRY_Y      = 32'd560;
  localparam int unsigned BOSS_OFFSCREEN_Y  = 32'd1024;
  localparam int unsigned BOSS_X_MAX        = 32'd1020;
  localparam int unsigned BOSS_SPEED_X      = 32'd8;
  localparam int unsigned BOSS_SPEED_Y      = 32'd4;
  localparam int unsigned BOSS_FLASH_FRAMES = 32'd16;

endpackage

// File: rtl/boss_sequencer.sv
// Boss fight sequencer: drives the boss sprite position, animation, health and
// hit-flash once per video frame, with start/hit pulses latched between frames.
module boss_sequencer
  import boss_pkg::*;
#(
  parameter int unsigned HEALTH_INIT  = BOSS_HEALTH_INIT,
  parameter int unsigned ENTRY_Y      = BOSS_ENTRY_Y,
  parameter int unsigned OFFSCREEN_Y  = BOSS_OFFSCREEN_Y,
  parameter int unsigned X_MAX        = BOSS_X_MAX,
  parameter int unsigned SPEED_X      = BOSS_SPEED_X,
  parameter int unsigned SPEED_Y      = BOSS_SPEED_Y,
  parameter int unsigned FLASH_FRAMES = BOSS_FLASH_FRAMES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        hit,
  output logic [11:0] boss_base_x,
  output logic [10:0] boss_base_y,
  output logic        boss_enable,
  output logic        boss_flash,
  output logic [1:0]  boss_frame,
  output logic [3:0]  boss_health,
  output logic        boss_defeated
);

  localparam int unsigned FLASH_W = $clog2(FLASH_FRAMES + 32'd1);
  localparam logic [11:0] X_START = 12'((X_MAX / 32'd2) / SPEED_X * SPEED_X);

  boss_state_e        state_r, state_n;
  logic [11:0]        base_x_r, base_x_n;
  logic [10:0]        base_y_r, base_y_n;
  logic               dir_left_r, dir_left_n;
  logic [FLASH_W-1:0] flash_cnt_r, flash_cnt_n;
  logic [2:0]         frame_cnt_r, frame_cnt_n;
  logic [1:0]         anim_r, anim_n;
  logic [3:0]         health_r, health_n;
  logic               start_pend_r, start_pend_n;
  logic               hit_pend_r, hit_pend_n;
  logic               enable_r, enable_n;
  logic               flash_r, flash_n;
  logic               defeated_r, defeated_n;

  logic               start_now_s;
  logic               hit_now_s;
  logic [12:0]        x_fwd_s;
  logic [11:0]        y_up_s;

  // A pulse arriving on the tick cycle itself still belongs to this frame.
  assign start_now_s = start_pend_r | start;
  assign hit_now_s   = hit_pend_r | hit;
  assign x_fwd_s     = {1'b0, base_x_r} + 13'(SPEED_X);
  assign y_up_s      = {1'b0, base_y_r} + 12'(SPEED_Y);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_x_r     <= 12'd0;
      base_y_r     <= 11'(OFFSCREEN_Y);
      dir_left_r   <= 1'b0;
      flash_cnt_r  <= '0;
      frame_cnt_r  <= 3'd0;
      anim_r       <= 2'd0;
      health_r     <= 4'(HEALTH_INIT);
      start_pend_r <= 1'b0;
      hit_pend_r   <= 1'b0;
      enable_r     <= 1'b0;
      flash_r      <= 1'b0;
      defeated_r   <= 1'b0;
    end else begin
      base_x_r     <= base_x_n;
      base_y_r     <= base_y_n;
      dir_left_r   <= dir_left_n;
      flash_cnt_r  <= flash_cnt_n;
      frame_cnt_r  <= frame_cnt_n;
      anim_r       <= anim_n;
      health_r     <= health_n;
      start_pend_r <= start_pend_n;
      hit_pend_r   <= hit_pend_n;
      enable_r     <= enable_n;
      flash_r      <= flash_n;
      defeated_r   <= defeated_n;
    end
  end

  // Next-state and per-frame update; nothing but the pending flags moves off-tick.
  always_comb begin
    state_n      = state_r;
    base_x_n     = base_x_r;
    base_y_n     = base_y_r;
    dir_left_n   = dir_left_r;
    flash_cnt_n  = flash_cnt_r;
    frame_cnt_n  = frame_cnt_r;
    anim_n       = anim_r;
    health_n     = health_r;
    start_pend_n = start_pend_r;
    hit_pend_n   = hit_pend_r;

    if (frame_tick) begin
      start_pend_n = 1'b0;
      hit_pend_n   = 1'b0;
      if (flash_cnt_r != '0) begin
        flash_cnt_n = flash_cnt_r - FLASH_W'(1);
      end else begin
        flash_cnt_n = flash_cnt_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (start_now_s) begin
            state_n  = ST_ENTER;
            base_x_n = X_START;
            health_n = 4'(HEALTH_INIT);
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_ENTER: begin
          if ({1'b0, base_y_r} <= 12'(ENTRY_Y + SPEED_Y)) begin
            base_y_n = 11'(ENTRY_Y);
            state_n  = ST_ATTACK;
          end else begin
            base_y_n = base_y_r - 11'(SPEED_Y);
          end
        end
        ST_ATTACK: begin
          frame_cnt_n = frame_cnt_r + 3'd1;
          if (frame_cnt_r == 3'd7) begin
            anim_n = anim_r + 2'd1;
          end else begin
            anim_n = anim_r;
          end
          if (hit_now_s && (flash_cnt_r == '0) && (health_r == 4'd1)) begin
            // Killing blow: freeze horizontally and start sinking.
            health_n    = 4'd0;
            flash_cnt_n = '0;
            state_n     = ST_DYING;
          end else begin
            if (hit_now_s && (flash_cnt_r == '0)) begin
              health_n    = health_r - 4'd1;
              flash_cnt_n = FLASH_W'(FLASH_FRAMES);
            end else begin
              health_n = health_r;
            end
            if (!dir_left_r) begin
              if (x_fwd_s > 13'(X_MAX)) begin
                base_x_n   = 12'(X_MAX);
                dir_left_n = 1'b1;
              end else begin
                base_x_n = x_fwd_s[11:0];
              end
            end else begin
              if (base_x_r < 12'(SPEED_X)) begin
                base_x_n   = 12'd0;
                dir_left_n = 1'b0;
              end else begin
                base_x_n = base_x_r - 12'(SPEED_X);
              end
            end
          end
        end
        ST_DYING: begin
          if (y_up_s >= 12'(OFFSCREEN_Y)) begin
            base_y_n = 11'(OFFSCREEN_Y);
            state_n  = ST_DONE;
          end else begin
            base_y_n = y_up_s[10:0];
          end
        end
        ST_DONE: begin
          state_n = ST_DONE;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end else begin
      start_pend_n = start_now_s;
      hit_pend_n   = hit_now_s;
    end

    enable_n   = (state_n == ST_ENTER) || (state_n == ST_ATTACK) || (state_n == ST_DYING);
    flash_n    = (flash_cnt_n != '0);
    defeated_n = (state_n == ST_DONE);
  end

  assign boss_base_x   = base_x_r;
  assign boss_base_y   = base_y_r;
  assign boss_enable   = enable_r;
  assign boss_flash    = flash_r;
  assign boss_frame    = anim_r;
  assign boss_health   = health_r;
  assign boss_defeated = defeated_r;

endmodule

// File: tb/tb_boss_sequencer.sv
// Self-checking bench for boss_sequencer: directed fight milestones plus randomized
// pulse timing, compared against a frame-level behavioural model of the boss.
module tb_boss_sequencer;

  localparam int M_IDLE = 0, M_ENTER = 1, M_ATTACK = 2, M_DYING = 3, M_DONE = 4;

  logic        clock = 1'b0;
  logic        reset, frame_tick, start, hit;
  logic [11:0] boss_base_x;
  logic [10:0] boss_base_y;
  logic        boss_enable, boss_flash, boss_defeated;
  logic [1:0]  boss_frame;
  logic [3:0]  boss_health;

  int errors = 0;
  int checks = 0;

  // Reference model state (frame-level view of the fight).
  int m_state, m_x, m_y, m_flash, m_fcnt, m_anim, m_health;
  bit m_right, m_sp, m_hp;

  boss_sequencer dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start), .hit(hit),
    .boss_base_x(boss_base_x), .boss_base_y(boss_base_y), .boss_enable(boss_enable),
    .boss_flash(boss_flash), .boss_frame(boss_frame), .boss_health(boss_health),
    .boss_defeated(boss_defeated)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_x = 0; m_y = 1024; m_flash = 0; m_fcnt = 0; m_anim = 0;
    m_health = 8; m_right = 1'b1; m_sp = 1'b0; m_hp = 1'b0;
  endtask

  task automatic model_frame(input bit s, input bit h);
    bit moving;
    moving = 1'b0;
    if (m_state == M_ATTACK && h && m_flash == 0) begin
      m_health = m_health - 1;
      if (m_health == 0) begin
        m_state = M_DYING;
        m_flash = 0;
        m_anim  = (m_anim + ((m_fcnt == 7) ? 1 : 0)) % 4;
        m_fcnt  = (m_fcnt + 1) % 8;
        return;
      end
      m_flash = 16;
      moving  = 1'b1;
    end else begin
      if (m_flash > 0) m_flash = m_flash - 1;
      moving = (m_state == M_ATTACK);
    end
    case (m_state)
      M_IDLE: if (s) begin m_state = M_ENTER; m_x = 504; m_health = 8; end
      M_ENTER: begin
        m_y = m_y - 4;
        if (m_y <= 560) begin m_y = 560; m_state = M_ATTACK; end
      end
      M_ATTACK: begin
        m_anim = (m_anim + ((m_fcnt == 7) ? 1 : 0)) % 4;
        m_fcnt = (m_fcnt + 1) % 8;
      end
      M_DYING: begin
        m_y = m_y + 4;
        if (m_y >= 1024) begin m_y = 1024; m_state = M_DONE; end
      end
      default: ;
    endcase
    if (moving) begin
      if (m_right) begin
        if (m_x + 8 > 1020) begin m_x = 1020; m_right = 1'b0; end
        else m_x = m_x + 8;
      end else begin
        if (m_x < 8) begin m_x = 0; m_right = 1'b1; end
        else m_x = m_x - 8;
      end
    end
  endtask

  task automatic check_outputs();
    chk("base_x", boss_base_x, m_x);
    chk("base_y", boss_base_y, m_y);
    chk("enable", boss_enable, (m_state == M_ENTER || m_state == M_ATTACK || m_state == M_DYING));
    chk("flash", boss_flash, (m_flash != 0));
    chk("frame", boss_frame, m_anim);
    chk("health", boss_health, m_health);
    chk("defeated", boss_defeated, (m_state == M_DONE));
  endtask

  // One clock with the given inputs; the model consumes pending pulses on ticks.
  task automatic cycle(input bit t, input bit s, input bit h);
    frame_tick = t; start = s; hit = h;
    @(posedge clock);
    #1;
    if (t) begin
      model_frame(m_sp | s, m_hp | h);
      m_sp = 1'b0; m_hp = 1'b0;
    end else begin
      m_sp = m_sp | s; m_hp = m_hp | h;
    end
    frame_tick = 1'b0; start = 1'b0; hit = 1'b0;
    check_outputs();
  endtask

  task automatic tick_after_gap(input bit hit_in_gap, input bit hit_on_tick);
    int gap;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, hit_in_gap && ($urandom_range(0, 3) == 0));
    cycle(1'b1, 1'b0, hit_on_tick);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_x"}, boss_base_x, 0);
    chk({tag, "_y"}, boss_base_y, 1024);
    chk({tag, "_en"}, boss_enable, 0);
    chk({tag, "_fl"}, boss_flash, 0);
    chk({tag, "_fr"}, boss_frame, 0);
    chk({tag, "_hp"}, boss_health, 8);
    chk({tag, "_def"}, boss_defeated, 0);
  endtask

  initial begin
    int dying_ticks;
    int n;
    reset = 1'b1; frame_tick = 1'b0; start = 1'b0; hit = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    // Ticks before any start leave the boss hidden.
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // Entry: 117 ticks, with a hit coincident with tick 40 and random stray hits.
    for (int i = 1; i <= 117; i++) tick_after_gap(1'b1, (i == 40) || ($urandom_range(0, 7) == 0));
    chk("entry_y", boss_base_y, 560);
    chk("entry_x", boss_base_x, 504);
    chk("entry_health", boss_health, 8);
    chk("entry_enable", boss_enable, 1);

    // Sweep right to the edge, clamp and reverse.
    for (int i = 0; i < 64; i++) tick_after_gap(1'b0, 1'b0);
    chk("edge_pre", boss_base_x, 1016);
    cycle(1'b1, 1'b0, 1'b0);
    chk("edge_clamp", boss_base_x, 1020);
    cycle(1'b1, 1'b0, 1'b0);
    chk("edge_reverse", boss_base_x, 1012);

    // Two hits in one frame count once; a hit during flash is ignored.
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("double_hit_health", boss_health, 7);
    chk("double_hit_flash", boss_flash, 1);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0, (i == 5));
      chk("flash_window", boss_flash, (i < 16));
    end
    chk("flash_hit_ignored", boss_health, 7);

    // Random fight to the finish; count the sinking frames.
    dying_ticks = 0;
    n = 0;
    while (m_state != M_DONE && n < 4000) begin
      if (boss_health == 4'd0 && !boss_defeated) dying_ticks++;
      tick_after_gap(1'b1, $urandom_range(0, 2) == 0);
      n++;
    end
    chk("fight_done", boss_defeated, 1);
    chk("dying_frames", dying_ticks, 116);
    chk("done_enable", boss_enable, 0);
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1);
    chk("done_sticky", boss_defeated, 1);

    // Second fight, aborted by reset between ticks mid-attack.
    reset = 1'b1;
    #2;
    model_reset();
    check_reset_values("rst2");
    @(negedge clock);
    reset = 1'b0;
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 116; i++) tick_after_gap(1'b1, $urandom_range(0, 3) == 0);
    for (int i = 0; i < 30; i++) tick_after_gap(1'b1, $urandom_range(0, 3) == 0);
    chk("attack_before_abort", boss_enable, 1);
    @(posedge clock);
    #3;
    frame_tick = 1'b1; hit = 1'b1; reset = 1'b1;
    #1;
    model_reset();
    check_reset_values("abort");
    @(posedge clock);
    #1;
    check_reset_values("abort_hold");
    frame_tick = 1'b0; hit = 1'b0; reset = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
